led_blink_stretcher: RTL and testbench

//  Output-side counterpart of input debouncing: turns 1-clk event pulses (e.g. debounced

---
 rtl/led_pkg.sv | 13 +
 rtl/sat_updown_counter.sv | 47 ++++
 rtl/led_blink_stretcher.sv | 113 +++++++++++
 tb/tb_led_blink_stretcher.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared types and helpers for the LED blink stretcher.
package led_pkg;

    typedef enum logic [1:0] {IDLE, ON, GAP} blink_state_t;

    // Duration counter width: enough for the longer phase, never zero.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sat_updown_counter.sv
// Saturating up/down counter with a registered overflow pulse.
module sat_updown_counter #(
    parameter int MAX = 7,
    localparam int W = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         ovf_o
);

    localparam logic [W-1:0] TOP = W'(MAX);

    logic [W-1:0] cnt_q, cnt_d;
    logic         ovf_q, ovf_d;

    // Simultaneous inc and dec cancel, so a full counter never overflows then.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !dec_i) begin
            if (cnt_q == TOP) ovf_d = 1'b1;
            else              cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign count_o = cnt_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/led_blink_stretcher.sv
// Stretches 1-clk event strobes into visible LED blinks with a queue.
module led_blink_stretcher
    import led_pkg::*;
#(
    parameter int ON_CYCLES      = 16,
    parameter int GAP_CYCLES     = 16,
    parameter int MAX_PENDING    = 7,
    parameter bit LED_ACTIVE_LOW = 1'b0,
    localparam int PW = $clog2(MAX_PENDING + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          event_in,
    input  logic          clr,
    output logic          led,
    output logic          busy,
    output logic [PW-1:0] pending,
    output logic          drop
);

    localparam int CW = cnt_width(ON_CYCLES, GAP_CYCLES);
    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

    blink_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lit_q;
    logic          q_inc, q_dec;
    logic          on_end, gap_end, has_pend;

    assign on_end   = (cnt_q == ON_LAST);
    assign gap_end  = (cnt_q == GAP_LAST);
    assign has_pend = (pending != '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_inc   = 1'b0;
        q_dec   = 1'b0;
        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (event_in) begin
                        state_d = ON;
                        cnt_d   = '0;
                    end
                end
                ON: begin
                    q_inc = event_in;
                    if (on_end) begin
                        state_d = GAP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        cnt_d = '0;
                        // A queued event wins; a fresh one then just refills its slot.
                        if (has_pend) begin
                            state_d = ON;
                            q_dec   = 1'b1;
                            q_inc   = event_in;
                        end else if (event_in) begin
                            state_d = ON;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        q_inc = event_in;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lit_q   <= (state_d == ON);
        end
    end

    sat_updown_counter #(
        .MAX(MAX_PENDING)
    ) u_pending (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr),
        .inc_i  (q_inc),
        .dec_i  (q_dec),
        .count_o(pending),
        .ovf_o  (drop)
    );

    assign led  = lit_q ^ LED_ACTIVE_LOW;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_led_blink_stretcher.sv
// Self-checking bench for led_blink_stretcher (ON=4, GAP=3, MAX_PENDING=2).
module tb_led_blink_stretcher;

    localparam int ON  = 4;
    localparam int GAP = 3;
    localparam int MAXP = 2;
    localparam int PW  = $clog2(MAXP + 1);

    logic          clk;
    logic          rst_n;
    logic          event_in;
    logic          clr;
    logic          led;
    logic          busy;
    logic [PW-1:0] pending;
    logic          drop;

    led_blink_stretcher #(
        .ON_CYCLES     (ON),
        .GAP_CYCLES    (GAP),
        .MAX_PENDING   (MAXP),
        .LED_ACTIVE_LOW(1'b0)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .event_in(event_in),
        .clr     (clr),
        .led     (led),
        .busy    (busy),
        .pending (pending),
        .drop    (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: blinks are time windows [start, start+ON+GAP).
    int cyc = 0;
    bit m_active = 0;
    int m_start = 0;
    int m_pend = 0;
    bit m_drop = 0;

    task automatic model_reset();
        m_active = 0;
        m_pend   = 0;
        m_drop   = 0;
    endtask

    task automatic model_step(input bit ev, input bit c);
        int phase;
        m_drop = 0;
        if (c) begin
            m_active = 0;
            m_pend   = 0;
        end else if (!m_active) begin
            if (ev) begin
                m_active = 1;
                m_start  = cyc + 1;
            end
        end else begin
            phase = cyc - m_start;
            if (phase == ON + GAP - 1) begin
                if (m_pend > 0) begin
                    m_start = cyc + 1;
                    m_pend  = m_pend - 1 + (ev ? 1 : 0);
                end else if (ev) begin
                    m_start = cyc + 1;
                end else begin
                    m_active = 0;
                end
            end else if (ev) begin
                if (m_pend < MAXP) m_pend++;
                else               m_drop = 1;
            end
        end
        cyc++;
    endtask

    function automatic int m_led();
        return (m_active && (cyc - m_start) < ON) ? 1 : 0;
    endfunction

    task automatic step(input bit ev, input bit c);
        event_in = ev;
        clr      = c;
        @(posedge clk);
        model_step(ev, c);
        #1;
        event_in = 1'b0;
        clr      = 1'b0;
    endtask

    task automatic clear_state();
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
    endtask

    typedef struct {
        bit ev;
        bit c;
        int led;
        int busy;
        int pend;
        int drop;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit ev, input bit c, input int l,
                       input int b, input int p, input int d);
        vec_t v;
        v.ev = ev; v.c = c; v.led = l; v.busy = b; v.pend = p; v.drop = d;
        tbl.push_back(v);
    endtask

    initial begin
        rst_n    = 1'b0;
        event_in = 1'b0;
        clr      = 1'b0;
        #12;
        check("reset led", int'(led), 0);
        check("reset busy", int'(busy), 0);
        check("reset pending", int'(pending), 0);
        check("reset drop", int'(drop), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Single event at cycle 0: lit 1-4, dark busy 5-7, idle from 8.
        add(1,0, 1,1,0,0);
        for (int i = 1; i <= 3; i++) add(0,0, 1,1,0,0);
        for (int i = 4; i <= 6; i++) add(0,0, 0,1,0,0);
        add(0,0, 0,0,0,0);
        add(0,0, 0,0,0,0);
        // Events at cycles 0-3: one drop, three blinks at 1, 8, 15.
        add(1,0, 1,1,0,0);
        add(1,0, 1,1,1,0);
        add(1,0, 1,1,2,0);
        add(1,0, 1,1,2,1);
        for (int i = 4; i <= 6; i++)   add(0,0, 0,1,2,0);
        for (int i = 7; i <= 10; i++)  add(0,0, 1,1,1,0);
        for (int i = 11; i <= 13; i++) add(0,0, 0,1,1,0);
        for (int i = 14; i <= 17; i++) add(0,0, 1,1,0,0);
        for (int i = 18; i <= 20; i++) add(0,0, 0,1,0,0);
        add(0,0, 0,0,0,0);

        foreach (tbl[i]) begin
            step(tbl[i].ev, tbl[i].c);
            check($sformatf("tbl%0d led", i), int'(led), tbl[i].led);
            check($sformatf("tbl%0d busy", i), int'(busy), tbl[i].busy);
            check($sformatf("tbl%0d pending", i), int'(pending), tbl[i].pend);
            check($sformatf("tbl%0d drop", i), int'(drop), tbl[i].drop);
        end

        // Event on the final GAP cycle with an empty queue.
        clear_state();
        step(1'b1, 1'b0);
        for (int t = 1; t <= 6; t++) begin
            step(1'b0, 1'b0);
            check($sformatf("lastgap busy c%0d", t + 1), int'(busy), 1);
        end
        step(1'b1, 1'b0);
        check("lastgap led c8", int'(led), 1);
        check("lastgap busy c8", int'(busy), 1);
        check("lastgap pending c8", int'(pending), 0);

        // Event coinciding with a consume at a full queue.
        clear_state();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("consume pre pending", int'(pending), 2);
        for (int t = 3; t <= 6; t++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("consume pending", int'(pending), 2);
        check("consume drop", int'(drop), 0);
        check("consume led", int'(led), 1);

        // Clear with a full queue; the event in the clear cycle is ignored.
        clear_state();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("clr led", int'(led), 0);
        check("clr busy", int'(busy), 0);
        check("clr pending", int'(pending), 0);
        check("clr drop", int'(drop), 0);
        for (int t = 0; t < 12; t++) begin
            step(1'b0, 1'b0);
            if (led || busy) begin
                check($sformatf("clr quiet t%0d", t), int'({led, busy}), 0);
            end
        end
        check("clr quiet end busy", int'(busy), 0);

        // Async reset mid-ON, then a normal blink.
        clear_state();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("arst pre pending", int'(pending), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst led", int'(led), 0);
        check("arst busy", int'(busy), 0);
        check("arst pending", int'(pending), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        step(1'b1, 1'b0);
        check("arst blink c1", int'(led), 1);
        for (int t = 2; t <= 4; t++) begin
            step(1'b0, 1'b0);
            check($sformatf("arst blink c%0d", t), int'(led), 1);
        end
        step(1'b0, 1'b0);
        check("arst blink c5 led", int'(led), 0);
        check("arst blink c5 busy", int'(busy), 1);

        // Random traffic against the reference model.
        clear_state();
        for (int t = 0; t < 1500; t++) begin
            bit ev, c;
            ev = ($urandom_range(0, 99) < 35);
            c  = ($urandom_range(0, 99) < 2);
            step(ev, c);
            check($sformatf("rnd%0d led", t), int'(led), m_led());
            check($sformatf("rnd%0d busy", t), int'(busy), int'(m_active));
            check($sformatf("rnd%0d pending", t), int'(pending), m_pend);
            check($sformatf("rnd%0d drop", t), int'(drop), int'(m_drop));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
